// File: rtl/wakeup_scoreboard_pkg.sv
// Shared CPU package for the register wakeup scoreboard.
// It holds the architectural register count, the register address type and the per-register state enum.
package wakeup_scoreboard_pkg;

    localparam int REG_NUM = 32;

    typedef logic [$clog2(REG_NUM)-1:0] reg_addr_t;

    // IDLE: value ready. PEND: busy and the producer has not been scheduled.
    // COUNT: busy and counting down to the first cycle the value can be forwarded.
    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_PEND  = 2'd1,
        SB_COUNT = 2'd2
    } sb_state_t;

endpackage

// File: rtl/wakeup_scoreboard_if.sv
// Dispatch, wakeup and writeback bundle for the wakeup scoreboard.
// Every *_valid / *_we bit qualifies its address only in the cycle it is high.
// There is no ready-side backpressure: the scoreboard accepts every qualified access in the same cycle.
interface wakeup_scoreboard_if #(
    parameter int REG_NUM = wakeup_scoreboard_pkg::REG_NUM,
    parameter int DISP_W  = 2,
    parameter int WAKE_W  = 2,
    parameter int WB_W    = 2,
    parameter int LAT_W   = 3
);
    localparam int ADDR_W = $clog2(REG_NUM);

    logic                              flush;
    logic [DISP_W-1:0][ADDR_W-1:0]     q_src1;
    logic [DISP_W-1:0][ADDR_W-1:0]     q_src2;
    logic [DISP_W-1:0][ADDR_W-1:0]     q_old_dest;
    logic [DISP_W-1:0]                 q_use_old_dest;
    logic [DISP_W-1:0]                 src1_ready;
    logic [DISP_W-1:0]                 src2_ready;
    logic [DISP_W-1:0]                 old_dest_ready;
    logic [DISP_W-1:0]                 map_we;
    logic [DISP_W-1:0][ADDR_W-1:0]     map_dest;
    logic [WAKE_W-1:0]                 wake_valid;
    logic [WAKE_W-1:0][ADDR_W-1:0]     wake_dest;
    logic [WAKE_W-1:0][LAT_W-1:0]      wake_lat;
    logic [WB_W-1:0]                   wb_valid;
    logic [WB_W-1:0][ADDR_W-1:0]       wb_dest;
    logic                              all_idle;

    modport master (
        output flush, q_src1, q_src2, q_old_dest, q_use_old_dest,
        output map_we, map_dest, wake_valid, wake_dest, wake_lat,
        output wb_valid, wb_dest,
        input  src1_ready, src2_ready, old_dest_ready, all_idle
    );

    modport slave (
        input  flush, q_src1, q_src2, q_old_dest, q_use_old_dest,
        input  map_we, map_dest, wake_valid, wake_dest, wake_lat,
        input  wb_valid, wb_dest,
        output src1_ready, src2_ready, old_dest_ready, all_idle
    );

endinterface

// File: rtl/wakeup_scoreboard_entry.sv
// One scoreboard register: IDLE/PEND/COUNT state plus its latency countdown.
// Request inputs are already address-decoded and priority-resolved by the top level.
module scoreboard_entry
    import wakeup_scoreboard_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_map,
    input  logic             i_idle_req,
    input  logic             i_cnt_req,
    input  logic [LAT_W-1:0] i_cnt_val,
    output sb_state_t        o_state,
    output logic             o_ready
);

    sb_state_t        r_state;
    sb_state_t        w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;

    // State and countdown register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: flush, then map, then release to IDLE, then countdown load, then natural countdown.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_flush) begin
            w_state_nxt = SB_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_map) begin
            w_state_nxt = SB_PEND;
            w_cnt_nxt   = '0;
        end else if (i_idle_req) begin
            w_state_nxt = SB_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_cnt_req) begin
            w_state_nxt = SB_COUNT;
            w_cnt_nxt   = i_cnt_val;
        end else if (r_state == SB_COUNT) begin
            if (r_cnt == LAT_W'(1)) begin
                w_state_nxt = SB_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - LAT_W'(1);
            end
        end
    end

    assign o_state = r_state;
    // The last countdown cycle already counts as ready, so consumers issue in the cycle the result forwards.
    assign o_ready = (r_state == SB_IDLE) || ((r_state == SB_COUNT) && (r_cnt == LAT_W'(1)));

endmodule

// File: rtl/wakeup_scoreboard.sv
// Register wakeup scoreboard: per-slot readiness queries with same-cycle bypass, plus busy tracking.
// Register 0 is constant ready and never instantiated.
module wakeup_scoreboard #(
    parameter int REG_NUM = wakeup_scoreboard_pkg::REG_NUM,
    parameter int DISP_W  = 2,
    parameter int WAKE_W  = 2,
    parameter int WB_W    = 2,
    parameter int LAT_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    wakeup_scoreboard_if.slave sb
);
    import wakeup_scoreboard_pkg::*;

    localparam int ADDR_W = $clog2(REG_NUM);

    logic [REG_NUM-1:1] w_map;
    logic [REG_NUM-1:1] w_idle_req;
    logic [REG_NUM-1:1] w_cnt_req;
    logic [LAT_W-1:0]   w_cnt_val [1:REG_NUM-1];
    sb_state_t          w_state   [1:REG_NUM-1];
    logic [REG_NUM-1:1] w_busy;
    logic [REG_NUM-1:0] w_ready;
    logic [DISP_W-1:0]  w_src1_rdy;
    logic [DISP_W-1:0]  w_src2_rdy;
    logic [DISP_W-1:0]  w_old_rdy;
    logic               r_all_idle;

    // Decode map/wb/wake ports into per-register requests; later wake ports override earlier ones.
    always_comb begin
        w_map      = '0;
        w_idle_req = '0;
        w_cnt_req  = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            w_cnt_val[i] = '0;
            for (int k = 0; k < DISP_W; k++) begin
                if (sb.map_we[k] && (sb.map_dest[k] == ADDR_W'(i))) w_map[i] = 1'b1;
            end
            for (int p = 0; p < WB_W; p++) begin
                if (sb.wb_valid[p] && (sb.wb_dest[p] == ADDR_W'(i))) w_idle_req[i] = 1'b1;
            end
            for (int p = 0; p < WAKE_W; p++) begin
                if (sb.wake_valid[p] && (sb.wake_dest[p] == ADDR_W'(i))) begin
                    if (sb.wake_lat[p] == '0) begin
                        w_idle_req[i] = 1'b1;
                    end else begin
                        w_cnt_req[i] = 1'b1;
                        w_cnt_val[i] = sb.wake_lat[p];
                    end
                end
            end
        end
    end

    assign w_ready[0] = 1'b1;

    for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_entry
        scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
            .clk        (clk),
            .reset      (reset),
            .i_flush    (sb.flush),
            .i_map      (w_map[gi]),
            .i_idle_req (w_idle_req[gi]),
            .i_cnt_req  (w_cnt_req[gi]),
            .i_cnt_val  (w_cnt_val[gi]),
            .o_state    (w_state[gi]),
            .o_ready    (w_ready[gi])
        );
        assign w_busy[gi] = (w_state[gi] != SB_IDLE);
    end

    // Per-slot readiness: stored state, bypassed by this cycle's releases, then masked by older slots' maps.
    always_comb begin
        logic [ADDR_W-1:0] v_addr;
        logic              v_rdy;
        v_addr     = '0;
        v_rdy      = 1'b0;
        w_src1_rdy = '0;
        w_src2_rdy = '0;
        w_old_rdy  = '0;
        for (int j = 0; j < DISP_W; j++) begin
            for (int s = 0; s < 3; s++) begin
                v_addr = (s == 0) ? sb.q_src1[j] : ((s == 1) ? sb.q_src2[j] : sb.q_old_dest[j]);
                v_rdy  = (v_addr == '0) || w_ready[v_addr];
                for (int p = 0; p < WB_W; p++) begin
                    if (sb.wb_valid[p] && (sb.wb_dest[p] == v_addr)) v_rdy = 1'b1;
                end
                for (int p = 0; p < WAKE_W; p++) begin
                    if (sb.wake_valid[p] && (sb.wake_lat[p] == '0) && (sb.wake_dest[p] == v_addr)) v_rdy = 1'b1;
                end
                for (int k = 0; k < DISP_W; k++) begin
                    if ((k < j) && sb.map_we[k] && (sb.map_dest[k] == v_addr) && (v_addr != '0)) v_rdy = 1'b0;
                end
                if (s == 0)      w_src1_rdy[j] = v_rdy;
                else if (s == 1) w_src2_rdy[j] = v_rdy;
                else             w_old_rdy[j]  = v_rdy || !sb.q_use_old_dest[j];
            end
        end
    end

    // Registered idle flag, one cycle behind the state vector.
    always_ff @(posedge clk) begin
        if (reset) r_all_idle <= 1'b1;
        else       r_all_idle <= ~|w_busy;
    end

    assign sb.src1_ready     = w_src1_rdy;
    assign sb.src2_ready     = w_src2_rdy;
    assign sb.old_dest_ready = w_old_rdy;
    assign sb.all_idle       = r_all_idle;

endmodule

// File: tb/tb_wakeup_scoreboard.sv
// Directed bench for the wakeup scoreboard.
module tb_wakeup_scoreboard;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wakeup_scoreboard_if sb_if ();

    wakeup_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    // Clock and counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic clear_drive();
        sb_if.flush      = 1'b0;
        sb_if.map_we     = '0;
        sb_if.map_dest   = '0;
        sb_if.wake_valid = '0;
        sb_if.wake_dest  = '0;
        sb_if.wake_lat   = '0;
        sb_if.wb_valid   = '0;
        sb_if.wb_dest    = '0;
    endtask

    task automatic clear_inputs();
        clear_drive();
        sb_if.q_src1         = '0;
        sb_if.q_src2         = '0;
        sb_if.q_old_dest     = '0;
        sb_if.q_use_old_dest = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        sb_if.q_src1[0] = 5'd5;
        sb_if.q_src1[1] = 5'd0;
        settle();
        n_checks++; if (sb_if.all_idle !== 1'b1) begin n_fail++; $display("FAIL reset_all_idle: got %b want 1", sb_if.all_idle); end
        n_checks++; if (sb_if.src1_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", sb_if.src1_ready); end
        // Busy register, then reset in the same cycle as another map
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd10;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd10;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL map_r10_pend: got %b want 0", sb_if.src1_ready[0]); end
        reset = 1'b1;
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd11;
        step();
        reset = 1'b0;
        clear_drive();
        sb_if.q_src1[0] = 5'd10; sb_if.q_src1[1] = 5'd11;
        settle();
        n_checks++; if (sb_if.src1_ready !== 2'b11) begin n_fail++; $display("FAIL reset_override: got %b want 11", sb_if.src1_ready); end
        n_checks++; if (sb_if.all_idle !== 1'b1) begin n_fail++; $display("FAIL reset_override_idle: got %b want 1", sb_if.all_idle); end
    endtask

    task automatic test_wake_latency();
        clear_inputs();
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd5;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd5;
        sb_if.wake_valid[0] = 1'b1; sb_if.wake_dest[0] = 5'd5; sb_if.wake_lat[0] = 3'd3;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL lat3_t0: got %b want 0", sb_if.src1_ready[0]); end
        step();
        clear_drive();
        for (int c = 1; c <= 2; c++) begin
            settle();
            n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL lat3_t%0d: got %b want 0", c, sb_if.src1_ready[0]); end
            step();
        end
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL lat3_t3: got %b want 1", sb_if.src1_ready[0]); end
        n_checks++; if (sb_if.all_idle !== 1'b0) begin n_fail++; $display("FAIL lat3_t3_idle: got %b want 0", sb_if.all_idle); end
        step();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL lat3_t4: got %b want 1", sb_if.src1_ready[0]); end
        n_checks++; if (sb_if.all_idle !== 1'b0) begin n_fail++; $display("FAIL lat3_t4_idle: got %b want 0", sb_if.all_idle); end
        step();
        n_checks++; if (sb_if.all_idle !== 1'b1) begin n_fail++; $display("FAIL lat3_t5_idle: got %b want 1", sb_if.all_idle); end
    endtask

    task automatic test_map_bypass();
        clear_inputs();
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd7;
        sb_if.q_src1[0] = 5'd7; sb_if.q_src1[1] = 5'd7; sb_if.q_src2[1] = 5'd7;
        settle();
        n_checks++; if (sb_if.src1_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bypass_s1_src1: got %b want 0", sb_if.src1_ready[1]); end
        n_checks++; if (sb_if.src2_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bypass_s1_src2: got %b want 0", sb_if.src2_ready[1]); end
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_s0_src1: got %b want 1", sb_if.src1_ready[0]); end
        step();
        clear_drive();
        sb_if.q_old_dest[0] = 5'd7; sb_if.q_use_old_dest[0] = 1'b0;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL r7_pend: got %b want 0", sb_if.src1_ready[0]); end
        n_checks++; if (sb_if.old_dest_ready[0] !== 1'b1) begin n_fail++; $display("FAIL old_dest_unused: got %b want 1", sb_if.old_dest_ready[0]); end
        sb_if.q_use_old_dest[0] = 1'b1;
        settle();
        n_checks++; if (sb_if.old_dest_ready[0] !== 1'b0) begin n_fail++; $display("FAIL old_dest_used: got %b want 0", sb_if.old_dest_ready[0]); end
        sb_if.wb_valid[1] = 1'b1; sb_if.wb_dest[1] = 5'd7;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL wb_bypass: got %b want 1", sb_if.src1_ready[0]); end
        step();
        clear_drive();
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL wb_idle: got %b want 1", sb_if.src1_ready[0]); end
    endtask

    task automatic test_map_over_wb();
        clear_inputs();
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd9;
        step();
        clear_drive();
        sb_if.map_we[1] = 1'b1; sb_if.map_dest[1] = 5'd9;
        sb_if.wb_valid[0] = 1'b1; sb_if.wb_dest[0] = 5'd9;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd9;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL map_over_wb: got %b want 0", sb_if.src1_ready[0]); end
        sb_if.wb_valid[0] = 1'b1; sb_if.wb_dest[0] = 5'd9;
        step();
        clear_drive();
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL r9_release: got %b want 1", sb_if.src1_ready[0]); end
    endtask

    task automatic test_reload();
        clear_inputs();
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd4;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd4;
        sb_if.wake_valid[0] = 1'b1; sb_if.wake_dest[0] = 5'd4; sb_if.wake_lat[0] = 3'd2;
        step();
        clear_drive();
        sb_if.wake_valid[1] = 1'b1; sb_if.wake_dest[1] = 5'd4; sb_if.wake_lat[1] = 3'd4;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL reload_t0: got %b want 0", sb_if.src1_ready[0]); end
        step();
        clear_drive();
        for (int c = 1; c <= 3; c++) begin
            settle();
            n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL reload_t%0d: got %b want 0", c, sb_if.src1_ready[0]); end
            step();
        end
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reload_t4: got %b want 1", sb_if.src1_ready[0]); end
        step();
    endtask

    task automatic test_priority();
        // Zero-latency wake beats a longer wake on the same register
        clear_inputs();
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd12;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd12;
        sb_if.wake_valid = 2'b11;
        sb_if.wake_dest[0] = 5'd12; sb_if.wake_lat[0] = 3'd0;
        sb_if.wake_dest[1] = 5'd12; sb_if.wake_lat[1] = 3'd3;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL l0_bypass: got %b want 1", sb_if.src1_ready[0]); end
        step();
        clear_drive();
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL l0_over_l3: got %b want 1", sb_if.src1_ready[0]); end
        // Highest wake port wins among nonzero latencies
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd13;
        step();
        clear_drive();
        sb_if.wake_valid = 2'b11;
        sb_if.wake_dest[0] = 5'd13; sb_if.wake_lat[0] = 3'd1;
        sb_if.wake_dest[1] = 5'd13; sb_if.wake_lat[1] = 3'd3;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd13;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL port_prio_t1: got %b want 0", sb_if.src1_ready[0]); end
        step();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b0) begin n_fail++; $display("FAIL port_prio_t2: got %b want 0", sb_if.src1_ready[0]); end
        step();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL port_prio_t3: got %b want 1", sb_if.src1_ready[0]); end
        // Writeback beats a same-cycle nonzero wake
        sb_if.map_we[0] = 1'b1; sb_if.map_dest[0] = 5'd14;
        step();
        clear_drive();
        sb_if.wb_valid[0] = 1'b1; sb_if.wb_dest[0] = 5'd14;
        sb_if.wake_valid[0] = 1'b1; sb_if.wake_dest[0] = 5'd14; sb_if.wake_lat[0] = 3'd3;
        step();
        clear_drive();
        sb_if.q_src1[0] = 5'd14;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL wb_over_l3: got %b want 1", sb_if.src1_ready[0]); end
        step();
        step();
    endtask

    task automatic test_flush();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            sb_if.map_we = 2'b11;
            sb_if.map_dest[0] = 5'(2 * c + 1);
            sb_if.map_dest[1] = 5'(2 * c + 2);
            step();
        end
        clear_drive();
        sb_if.q_src1[0] = 5'd1; sb_if.q_src2[0] = 5'd2; sb_if.q_old_dest[0] = 5'd3;
        sb_if.q_src1[1] = 5'd4; sb_if.q_src2[1] = 5'd5; sb_if.q_old_dest[1] = 5'd6;
        sb_if.q_use_old_dest = 2'b11;
        sb_if.flush = 1'b1;
        sb_if.wake_valid[0] = 1'b1; sb_if.wake_dest[0] = 5'd3; sb_if.wake_lat[0] = 3'd2;
        sb_if.wb_valid[0] = 1'b1; sb_if.wb_dest[0] = 5'd20;
        settle();
        n_checks++; if (sb_if.all_idle !== 1'b0) begin n_fail++; $display("FAIL flush_pre_idle: got %b want 0", sb_if.all_idle); end
        sb_if.map_we[1] = 1'b1; sb_if.map_dest[1] = 5'd8;
        step();
        clear_drive();
        settle();
        n_checks++; if ({sb_if.src1_ready, sb_if.src2_ready, sb_if.old_dest_ready} !== 6'b111111) begin
            n_fail++; $display("FAIL flush_ready: got %b want 111111", {sb_if.src1_ready, sb_if.src2_ready, sb_if.old_dest_ready});
        end
        n_checks++; if (sb_if.all_idle !== 1'b0) begin n_fail++; $display("FAIL flush_t1_idle: got %b want 0", sb_if.all_idle); end
        sb_if.q_src1[0] = 5'd8;
        settle();
        n_checks++; if (sb_if.src1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL flush_over_map: got %b want 1", sb_if.src1_ready[0]); end
        step();
        n_checks++; if (sb_if.all_idle !== 1'b1) begin n_fail++; $display("FAIL flush_t2_idle: got %b want 1", sb_if.all_idle); end
        n_checks++; if (sb_if.old_dest_ready[0] !== 1'b1) begin n_fail++; $display("FAIL flush_over_wake: got %b want 1", sb_if.old_dest_ready[0]); end
    endtask

    task automatic test_r0();
        clear_inputs();
        sb_if.map_we = 2'b11; sb_if.map_dest[0] = 5'd0; sb_if.map_dest[1] = 5'd0;
        sb_if.q_src1[1] = 5'd0; sb_if.q_old_dest[1] = 5'd0; sb_if.q_use_old_dest[1] = 1'b1;
        sb_if.wake_valid[0] = 1'b1; sb_if.wake_dest[0] = 5'd0; sb_if.wake_lat[0] = 3'd5;
        settle();
        n_checks++; if ({sb_if.src1_ready[1], sb_if.old_dest_ready[1]} !== 2'b11) begin
            n_fail++; $display("FAIL r0_map_bypass: got %b want 11", {sb_if.src1_ready[1], sb_if.old_dest_ready[1]});
        end
        step();
        clear_drive();
        settle();
        n_checks++; if (sb_if.src1_ready[1] !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", sb_if.src1_ready[1]); end
        n_checks++; if (sb_if.all_idle !== 1'b1) begin n_fail++; $display("FAIL r0_idle_t1: got %b want 1", sb_if.all_idle); end
        step();
        n_checks++; if (sb_if.all_idle !== 1'b1) begin n_fail++; $display("FAIL r0_idle_t2: got %b want 1", sb_if.all_idle); end
    endtask

    // Sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_wake_latency();
        test_map_bypass();
        test_map_over_wb();
        test_reload();
        test_priority();
        test_flush();
        test_r0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
